// File: rtl/softmax_pkg.sv
// softmax_pkg
//   Shared definitions for the Softmax datapath stages.
//   - DATA_W_DEF / ROW_LEN_DEF : default element width and row length.
//   - SAT_MIN                  : most negative value at the default width,
//                                the clamp value of the max-shift subtraction.
//   - state_e                  : FILL (collecting a row) / DRAIN (streaming it).
package softmax_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int ROW_LEN_DEF = 16;

   localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

endpackage

// File: rtl/softmax_sat_sub.sv
// softmax_sat_sub
//   Combinational a - b on signed DATA_W operands. The difference is formed
//   in DATA_W+1 bits; a result below -2^(DATA_W-1) clamps to -2^(DATA_W-1).
//   No positive clamping: in the max-shift use b >= a, so the result is <= 0.
//   Ports:
//     a_i    in  DATA_W  signed minuend
//     b_i    in  DATA_W  signed subtrahend
//     diff_o out DATA_W  signed saturated difference
module softmax_sat_sub
   import softmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic signed [DATA_W-1:0] diff_o
);

   localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W:0] diff_w;

   // Sign-extend both operands so the subtraction cannot wrap.
   assign diff_w = {a_i[DATA_W-1], a_i} - {b_i[DATA_W-1], b_i};

   always_comb begin
      diff_o = diff_w[DATA_W-1:0];
      // Top two bits 10: negative and out of range for DATA_W bits.
      if (diff_w[DATA_W] && !diff_w[DATA_W-1]) begin
         diff_o = MIN_V;
      end
   end

endmodule

// File: rtl/softmax_max_subtract.sv
// softmax_max_subtract
//   Numerically-stable max-shift ahead of the Softmax exp stage. Buffers one
//   row of ROW_LEN signed elements while tracking the row maximum, then
//   streams saturated x_i - row_max downstream. One row in flight at a time.
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high; a producer holds valid and data stable until that edge.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   input element valid
//     in_ready   out  element accepted this cycle (FILL state only)
//     in_data    in   DATA_W signed input element
//     out_valid  out  output element valid
//     out_ready  in   downstream accepts output element
//     out_data   out  DATA_W saturated x_i - row_max
//     out_last   out  final element of the row
//     row_max    out  max of the row currently draining
module softmax_max_subtract
   import softmax_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROW_LEN = ROW_LEN_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic signed [DATA_W-1:0] row_max
);

   localparam int IDX_W = $clog2(ROW_LEN);
   // Read counter needs one extra value: ROW_LEN means "row fully loaded out".
   localparam int CNT_W = $clog2(ROW_LEN + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW_LEN - 1);
   localparam logic [CNT_W-1:0] ROW_CNT  = CNT_W'(ROW_LEN);

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          wr_idx_q;
   logic [CNT_W-1:0]          rd_idx_q;
   logic signed [DATA_W-1:0]  max_acc_q;
   logic signed [DATA_W-1:0]  row_max_q;
   logic signed [DATA_W-1:0]  out_data_q;
   logic                      out_last_q;
   logic                      out_valid_q;
   logic signed [DATA_W-1:0]  buf_q [ROW_LEN];

   logic                      accept;
   logic                      last_accept;
   logic                      load;
   logic                      row_done;
   logic signed [DATA_W-1:0]  max_next;
   logic signed [DATA_W-1:0]  sat_w;

   assign accept      = in_valid && in_ready;
   assign last_accept = accept && (wr_idx_q == LAST_IDX);
   assign load        = (state_q == DRAIN) && (!out_valid_q || out_ready) && (rd_idx_q < ROW_CNT);
   // Final handshake; rd_idx is exhausted here so nothing new loads alongside it.
   assign row_done    = (state_q == DRAIN) && out_valid_q && out_ready && out_last_q && !load;

   // First element seeds the accumulator; ties keep the stored value.
   assign max_next = (wr_idx_q == '0) ? in_data :
                     ((in_data > max_acc_q) ? in_data : max_acc_q);

   softmax_sat_sub #(.DATA_W(DATA_W)) u_sat_sub (
      .a_i    (buf_q[rd_idx_q[IDX_W-1:0]]),
      .b_i    (row_max_q),
      .diff_o (sat_w)
   );

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (last_accept) state_d = DRAIN;
         DRAIN:   if (row_done)    state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // FSM: outputs. Gated by rst so nothing is accepted while reset is held.
   always_comb begin
      in_ready = (state_q == FILL) && !rst;
   end

   // Indices, max tracking and output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         max_acc_q   <= '0;
         row_max_q   <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            max_acc_q <= max_next;
            if (last_accept) begin
               wr_idx_q  <= '0;
               rd_idx_q  <= '0;
               row_max_q <= max_next;
            end else begin
               wr_idx_q <= wr_idx_q + 1'b1;
            end
         end
         if (load) begin
            out_data_q  <= sat_w;
            out_last_q  <= (rd_idx_q == LAST_CNT);
            out_valid_q <= 1'b1;
            rd_idx_q    <= rd_idx_q + 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (row_done) begin
               rd_idx_q <= '0;
            end
         end
      end
   end

   // Row buffer: plain flops, not reset; contents are only read after a full fill.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[wr_idx_q] <= in_data;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign row_max   = row_max_q;

endmodule
